// File: rtl/sap_datapath.sv
// sap_datapath: execution side of the SAP machine.
// Decodes the 15-bit control word from the sequencer into bus-source
// enables and register loads. Holds PC, MAR, IR, A/B/C/D, the output
// register, the carry/zero flags and the program memory.
module sap_datapath #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [14:0]   control_lines,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] bus,
  output logic [3:0]    reg_ir,
  output logic [1:0]    flag_lines,
  output logic [DW-1:0] out_port,
  output logic          out_valid,
  output logic          bus_conflict
);

  // Control word bit positions
  localparam int BIT_EP = 0;
  localparam int BIT_LM = 1;
  localparam int BIT_C  = 2;
  localparam int BIT_LI = 3;
  localparam int BIT_EM = 4;
  localparam int BIT_LA = 5;
  localparam int BIT_EI = 6;
  localparam int BIT_LB = 7;
  localparam int BIT_LC = 8;
  localparam int BIT_LD = 9;
  localparam int BIT_EA = 10;
  localparam int BIT_EB = 11;
  localparam int BIT_ES = 12;
  localparam int BIT_LO = 13;
  localparam int BIT_LP = 14;

  logic ep, lm, cinc, li, em, la, ei, lb, lc, ld, ea, eb, es, lo, lp;

  assign ep   = control_lines[BIT_EP];
  assign lm   = control_lines[BIT_LM];
  assign cinc = control_lines[BIT_C];
  assign li   = control_lines[BIT_LI];
  assign em   = control_lines[BIT_EM];
  assign la   = control_lines[BIT_LA];
  assign ei   = control_lines[BIT_EI];
  assign lb   = control_lines[BIT_LB];
  assign lc   = control_lines[BIT_LC];
  assign ld   = control_lines[BIT_LD];
  assign ea   = control_lines[BIT_EA];
  assign eb   = control_lines[BIT_EB];
  assign es   = control_lines[BIT_ES];
  assign lo   = control_lines[BIT_LO];
  assign lp   = control_lines[BIT_LP];

  logic [AW-1:0] pc;
  logic [AW-1:0] mar;
  logic [DW-1:0] ir;
  logic [DW-1:0] reg_a;
  logic [DW-1:0] reg_b;
  logic [DW-1:0] reg_c;
  logic [DW-1:0] reg_d;
  logic          carry;
  logic          zero;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] mem_rd;
  logic [DW:0]   alu_sum;
  logic [5:0]    enables;
  logic          multi_enable;
  logic          es_wins;

  // C and D have no bus enable in this control word, so nothing reads
  // them internally; collecting them here marks that as intentional.
  logic [2*DW-1:0] unused_cd;
  assign unused_cd = {reg_c, reg_d};

  // Memory read is asynchronous from MAR; a write at the same edge is
  // seen only afterwards, so same-cycle reads return the old data.
  assign mem_rd  = mem[mar];
  assign alu_sum = {1'b0, reg_a} + {1'b0, reg_b};
  assign enables = {es, eb, ea, ei, em, ep};
  assign multi_enable = ($countones(enables) > 1);
  assign es_wins = es & ~(ep | em | ei | ea | eb);

  assign reg_ir     = ir[DW-1 -: 4];
  assign flag_lines = {zero, carry};

  // Bus source mux, fixed priority EP > EM > EI > EA > EB > ES
  always_comb begin
    bus = '0;
    if (ep)      bus = {{(DW-AW){1'b0}}, pc};
    else if (em) bus = mem_rd;
    else if (ei) bus = {{(DW-4){1'b0}}, ir[3:0]};
    else if (ea) bus = reg_a;
    else if (eb) bus = reg_b;
    else if (es) bus = alu_sum[DW-1:0];
  end

  // Program memory write port; independent of reset so loading can
  // happen while the datapath is held in reset
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // Register file, PC, flags, output register and sticky conflict flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      mar          <= '0;
      ir           <= '0;
      reg_a        <= '0;
      reg_b        <= '0;
      reg_c        <= '0;
      reg_d        <= '0;
      out_port     <= '0;
      out_valid    <= 1'b0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      if (lm) mar      <= bus[AW-1:0];
      if (li) ir       <= bus;
      if (la) reg_a    <= bus;
      if (lb) reg_b    <= bus;
      if (lc) reg_c    <= bus;
      if (ld) reg_d    <= bus;
      if (lo) out_port <= bus;
      out_valid <= lo;
      if (lp)        pc <= bus[AW-1:0];
      else if (cinc) pc <= pc + {{(AW-1){1'b0}}, 1'b1};
      if (es_wins && la) begin
        carry <= alu_sum[DW];
        zero  <= (alu_sum[DW-1:0] == '0);
      end
      if (multi_enable) bus_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: scoreboard bench for sap_datapath. Stimulus drives
// one control word per cycle and pushes the expected outputs from a
// behavioural machine model; a monitor pops and compares at negedge.
module tb_sap_datapath;

  localparam logic [14:0] CEP = 15'h0001;
  localparam logic [14:0] CLM = 15'h0002;
  localparam logic [14:0] CC  = 15'h0004;
  localparam logic [14:0] CLI = 15'h0008;
  localparam logic [14:0] CEM = 15'h0010;
  localparam logic [14:0] CLA = 15'h0020;
  localparam logic [14:0] CEI = 15'h0040;
  localparam logic [14:0] CLB = 15'h0080;
  localparam logic [14:0] CLC = 15'h0100;
  localparam logic [14:0] CLD = 15'h0200;
  localparam logic [14:0] CEA = 15'h0400;
  localparam logic [14:0] CEB = 15'h0800;
  localparam logic [14:0] CES = 15'h1000;
  localparam logic [14:0] CLO = 15'h2000;
  localparam logic [14:0] CLP = 15'h4000;
  localparam logic [14:0] EN_MASK   = 15'h1C51;
  localparam logic [14:0] LOAD_MASK = 15'h63AE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] control_lines = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [7:0]  bus;
  logic [3:0]  reg_ir;
  logic [1:0]  flag_lines;
  logic [7:0]  out_port;
  logic        out_valid;
  logic        bus_conflict;

  sap_datapath #(.DW(8), .AW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .control_lines(control_lines),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .bus          (bus),
    .reg_ir       (reg_ir),
    .flag_lines   (flag_lines),
    .out_port     (out_port),
    .out_valid    (out_valid),
    .bus_conflict (bus_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         chk;
    logic [7:0] bus;
    logic [3:0] ir;
    logic [1:0] flags;
    logic [7:0] outp;
    logic       ov;
    logic       bc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Behavioural machine state
  bit   m_known = 0;
  int   m_pc, m_mar, m_ir, m_a, m_b, m_c, m_d, m_out;
  bit   m_ov, m_carry, m_zero, m_bc;
  int   m_mem [16];

  function automatic int modelBus(input logic [14:0] ctrl);
    if (ctrl & CEP)      return m_pc;
    else if (ctrl & CEM) return m_mem[m_mar];
    else if (ctrl & CEI) return m_ir % 16;
    else if (ctrl & CEA) return m_a;
    else if (ctrl & CEB) return m_b;
    else if (ctrl & CES) return (m_a + m_b) % 256;
    return 0;
  endfunction

  task automatic applyStimulus(input logic [14:0] ctrl, input logic r,
                               input logic we, input logic [3:0] wa,
                               input logic [7:0] wd);
    exp_t e;
    int   b, sum, nen;
    @(posedge clk);
    #1;
    control_lines = ctrl;
    rst       = r;
    prog_we   = we;
    prog_addr = wa;
    prog_data = wd;
    b = modelBus(ctrl);
    e.chk   = m_known;
    e.bus   = b[7:0];
    e.ir    = 4'(m_ir / 16);
    e.flags = {m_zero, m_carry};
    e.outp  = 8'(m_out);
    e.ov    = m_ov;
    e.bc    = m_bc;
    sb.push_back(e);
    sum = m_a + m_b;
    nen = $countones(ctrl & EN_MASK);
    if (r) begin
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_c = 0; m_d = 0;
      m_out = 0; m_ov = 0; m_carry = 0; m_zero = 0; m_bc = 0;
      m_known = 1;
    end else begin
      if (ctrl & CLM) m_mar = b % 16;
      if (ctrl & CLI) m_ir = b;
      if (ctrl & CLA) m_a = b;
      if (ctrl & CLB) m_b = b;
      if (ctrl & CLC) m_c = b;
      if (ctrl & CLD) m_d = b;
      if (ctrl & CLO) m_out = b;
      m_ov = ((ctrl & CLO) != 0);
      if (ctrl & CLP)     m_pc = b % 16;
      else if (ctrl & CC) m_pc = (m_pc + 1) % 16;
      if (nen == 1 && (ctrl & CES) && (ctrl & CLA)) begin
        m_carry = (sum > 255);
        m_zero  = ((sum % 256) == 0);
      end
      if (nen >= 2) m_bc = 1;
    end
    if (we) m_mem[wa] = wd;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t",
               name, act, expv, $time);
    end
  endtask

  // Monitor: compare current DUT outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          checkOutput("bus",          bus,                  e.bus);
          checkOutput("reg_ir",       {4'h0, reg_ir},       {4'h0, e.ir});
          checkOutput("flag_lines",   {6'h0, flag_lines},   {6'h0, e.flags});
          checkOutput("out_port",     out_port,             e.outp);
          checkOutput("out_valid",    {7'h0, out_valid},    {7'h0, e.ov});
          checkOutput("bus_conflict", {7'h0, bus_conflict}, {7'h0, e.bc});
        end
      end
    end
  end

  // Place a value on the bus through memory and capture it into dest
  task automatic loadVia(input logic [7:0] value, input logic [14:0] dest);
    applyStimulus(CEP | CLM, 1'b0, 1'b1, 4'(m_pc), value);
    applyStimulus(CEM | dest | CC, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic stepPcTo(input int target);
    for (int i = 0; i < 16 && m_pc != target; i++)
      applyStimulus(CC, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic idle();
    applyStimulus(15'h0000, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  // Watchdog so a stalled run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Stimulus: directed scenarios, then randomized control words
  initial begin
    logic [14:0] ctrl;
    logic [7:0]  wd;
    int          sel;
    for (int i = 0; i < 16; i++) begin
      wd = 8'($urandom);
      if (i == 0) wd = 8'h1A;
      if (i == 3) wd = 8'h77;
      applyStimulus(15'h0000, 1'b1, 1'b1, 4'(i), wd);
    end
    applyStimulus(15'h0000, 1'b1, 1'b0, 4'h0, 8'h00);

    // Fetch: MAR<-PC, then IR<-mem[MAR], PC++
    applyStimulus(CEP | CLM, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(CC | CLI | CEM, 1'b0, 1'b0, 4'h0, 8'h00);
    idle();

    // ALU: A<-IR[3:0]=5, B=3, A<-A+B; then 0xFF+0x01
    loadVia(8'h05, CLI);
    applyStimulus(CEI | CLA, 1'b0, 1'b0, 4'h0, 8'h00);
    loadVia(8'h03, CLB);
    applyStimulus(CES | CLA, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(CEA, 1'b0, 1'b0, 4'h0, 8'h00);
    loadVia(8'hFF, CLA);
    loadVia(8'h01, CLB);
    applyStimulus(CES | CLA, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(CEA, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(CEB | CLA, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(CEA, 1'b0, 1'b0, 4'h0, 8'h00);

    // PC wrap 15->0, and LP overriding C
    stepPcTo(15);
    applyStimulus(CC, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(CEP, 1'b0, 1'b0, 4'h0, 8'h00);
    loadVia(8'h09, CLI);
    stepPcTo(4);
    applyStimulus(CC | CEI | CLP, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(CEP, 1'b0, 1'b0, 4'h0, 8'h00);

    // Output register pulse, then an all-zero word holds everything
    loadVia(8'h42, CLA);
    applyStimulus(CEA | CLO, 1'b0, 1'b0, 4'h0, 8'h00);
    idle();
    idle();
    applyStimulus(CEA, 1'b0, 1'b0, 4'h0, 8'h00);

    // Contention sets the sticky flag
    loadVia(8'h11, CLA);
    loadVia(8'h22, CLB);
    applyStimulus(CEA | CEB | CLC, 1'b0, 1'b0, 4'h0, 8'h00);
    idle();
    applyStimulus(CEB, 1'b0, 1'b0, 4'h0, 8'h00);
    idle();

    // Reset mid-sequence; memory survives it
    applyStimulus(15'h0000, 1'b0, 1'b1, 4'h3, 8'h77);
    applyStimulus(CC | CLM, 1'b1, 1'b0, 4'h0, 8'h00);
    idle();
    stepPcTo(3);
    applyStimulus(CEP | CLM, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(CEM, 1'b0, 1'b0, 4'h0, 8'h00);

    // Randomized control words
    for (int n = 0; n < 400; n++) begin
      sel  = $urandom_range(0, 9);
      ctrl = 15'(($urandom & 32'h7FFF)) & LOAD_MASK;
      if (sel >= 3 && sel < 8) begin
        case ($urandom_range(0, 5))
          0: ctrl |= CEP;
          1: ctrl |= CEM;
          2: ctrl |= CEI;
          3: ctrl |= CEA;
          4: ctrl |= CEB;
          default: ctrl |= CES;
        endcase
      end else if (sel >= 8) begin
        ctrl |= 15'($urandom & 32'h7FFF) & EN_MASK;
      end
      applyStimulus(ctrl, ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 3) == 0),
                    4'($urandom), 8'($urandom));
    end
    idle();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
- Execution-side counterpart of the SAP control sequencer: consumes the 15-bit control word and performs the bus transfers, register loads, PC increment and ALU add it names.
- Holds PC, MAR, IR, general registers A/B/C/D, the output register, the carry/zero flags and a 16x8 program memory.
- Drives the shared 8-bit bus and returns the opcode nibble and flags to the sequencer.

Parameters:
- DW, 8, data/bus width in bits.
- AW, 4, address width; the memory depth is 2^AW.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- control_lines  input  15  control word from the sequencer. Bit map: 0 EP, 1 LM, 2 C, 3 LI, 4 EM, 5 LA, 6 EI, 7 LB, 8 LC, 9 LD, 10 EA, 11 EB, 12 ES, 13 LO, 14 LP.
- prog_we  input  1  program-memory write strobe.
- prog_addr  input  AW  program-memory write address.
- prog_data  input  DW  program-memory write data.
- bus  output  DW  current bus value (combinational).
- reg_ir  output  4  IR[7:4], the opcode nibble.
- flag_lines  output  2  {zero, carry}.
- out_port  output  DW  output register.
- out_valid  output  1  one-cycle pulse after an LO load.
- bus_conflict  output  1  sticky contention error.

Behaviour:
- Reset (rst high at a clock edge): PC, MAR, IR, A, B, C, D, out_port, flags, out_valid and bus_conflict all clear to 0. Memory contents are NOT cleared.
- Bus source (combinational), priority EP > EM > EI > EA > EB > ES:
  - EP drives {0, PC}.
  - EM drives mem[MAR].
  - EI drives {0, IR[3:0]}.
  - EA drives A; EB drives B.
  - ES drives the ALU sum A+B truncated to DW.
  - No enable asserted: bus = 0.
- Loads: every asserted L* captures the bus at the next rising edge; all asserted loads take effect together.
  - LM captures bus[AW-1:0].
  - LI captures the full bus.
  - LP captures bus[AW-1:0].
  - LO loads out_port and sets out_valid high for exactly that following cycle.
- PC:
  - C increments PC modulo 2^AW (15 wraps to 0).
  - LP and C together: LP wins; no increment.
- Register reads during a load use old values: EA with LA keeps A; EB|LA copies B into A in one edge.
- Flags update only on an edge where ES is the winning bus source and LA is asserted:
  - carry = bit DW of A+B.
  - zero = (sum[DW-1:0] == 0).
  - Otherwise the flags hold.
- Contention: if two or more enables are high, the priority winner drives the bus and bus_conflict sets at the next edge. It stays set until rst.
- Memory:
  - prog_we writes prog_data to mem[prog_addr] at the edge; this works during rst too.
  - A read of the same address in the same cycle returns the old data.
- Control word of all zeros: no state changes except memory writes; out_valid returns to 0.
- Reset has priority over all loads, increments and flag updates, and applies mid-instruction.
- Single-cycle behaviour throughout; no internal FSM beyond the registers. Instruction sequencing stays in the sequencer.

Test Plan:
- Preload mem[0]=0x1A, hold rst, release; apply EP|LM, then C|LI|EM -> MAR=0, IR=0x1A, PC=1, reg_ir=0x1, bus=0x1A during the EM cycle.
- Apply IR=0x05 with EI|LA, then A=0x05/B=0x03 with ES|LA -> A=0x08, carry=0, zero=0. Then A=0xFF/B=0x01 with ES|LA -> A=0x00, flag_lines=2'b11.
- PC=15 with C -> PC=0. PC=4 with C|EI|LP and IR[3:0]=0x9 -> PC=9, no increment.
- A=0x42 with EA|LO -> out_port=0x42, out_valid=1 for one cycle, then 0. Control word 0 -> all registers hold.
- EA|EB|LC with A=0x11/B=0x22 -> C=0x11, bus_conflict=1. Remains 1 after further clean words; clears only on rst.
- Mid-sequence rst with C|LM active -> PC=MAR=0, flags=0, bus_conflict=0. Previously written mem[3]=0x77 is still read back via MAR=3 with EM.
